// File: rtl/mdio_bank_controller_if.sv
// Command/response bus between the management register block and the shared MDIO frame engine.
interface mdio_bank_controller_if #(
  parameter int CHAN_BITS = 2
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CHAN_BITS-1:0] cmd_chan;
  logic                 cmd_c45;
  logic [1:0]           cmd_op;
  logic [4:0]           cmd_phy_addr;
  logic [4:0]           cmd_reg_addr;
  logic [15:0]          cmd_data;
  logic                 rsp_valid;
  logic [CHAN_BITS-1:0] rsp_chan;
  logic [15:0]          rsp_data;

  modport master (
    output cmd_valid, cmd_chan, cmd_c45, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_chan, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_c45, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_chan, rsp_data
  );
endinterface

// File: rtl/mdio_bank_controller.sv
// Shared Clause 22/45 MDIO frame engine serving NUM_CHANNELS buses, one frame in flight,
// with MDC held gated for GATE_CYCLES after reset.
module mdio_bank_controller #(
  parameter int NUM_CHANNELS = 3,
  parameter int CHAN_BITS    = 2,
  parameter int CLK_DIV      = 75,
  parameter int PREAMBLE_EN  = 1,
  parameter int GATE_CYCLES  = 1048576
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  mdio_bank_controller_if.slave   bus,
  output logic [NUM_CHANNELS-1:0] chan_busy,
  output logic [NUM_CHANNELS-1:0] mdc,
  output logic [NUM_CHANNELS-1:0] mdio_tx_data,
  output logic [NUM_CHANNELS-1:0] mdio_tx_en,
  input  logic [NUM_CHANNELS-1:0] mdio_rx_data
);
  localparam int GATE_W     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME_BITS = (PREAMBLE_EN != 0) ? 64 : 32;
  localparam int BITS_W     = $clog2(FRAME_BITS + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BITS_W-1:0] BITS_INIT = BITS_W'(FRAME_BITS);
  localparam logic [BITS_W-1:0] BITS_ONE  = BITS_W'(1);
  // TA plus 16 data bits remain when the first turnaround bit is on the wire
  localparam logic [BITS_W-1:0] TA_BITS   = BITS_W'(18);

  typedef enum logic [1:0] {GATED, IDLE, SHIFT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [GATE_W-1:0]       gate_q, gate_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    high_q, high_d;
  logic [BITS_W-1:0]       bits_q, bits_d;
  logic [63:0]             frame_q, frame_d;
  logic [15:0]             rd_q, rd_d;
  logic                    read_q, read_d;
  logic [CHAN_BITS-1:0]    chan_q, chan_d;
  logic                    chan_ok_q, chan_ok_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [CHAN_BITS-1:0]    rsp_chan_q, rsp_chan_d;
  logic [15:0]             rsp_data_q, rsp_data_d;

  logic [NUM_CHANNELS-1:0] sel;
  logic                    ready;
  logic                    accept;
  logic                    rx_bit;
  logic                    tx_en_cur;

  function automatic logic is_read(input logic c45, input logic [1:0] op);
    return c45 ? op[1] : (op == 2'b10);
  endfunction

  // ST is 00 for Clause 45 and 01 for Clause 22; TA is always sent as 10
  function automatic logic [63:0] build_frame(input logic c45, input logic [1:0] op,
                                              input logic [4:0] phy, input logic [4:0] regad,
                                              input logic [15:0] data);
    logic [31:0] body;
    body = {1'b0, ~c45, op, phy, regad, 2'b10, data};
    return (PREAMBLE_EN != 0) ? {32'hFFFF_FFFF, body} : {body, 32'h0000_0000};
  endfunction

  assign ready         = (state_q == IDLE) && !rsp_valid_q;
  assign accept        = ready && bus.cmd_valid;
  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_chan  = rsp_chan_q;
  assign bus.rsp_data  = rsp_data_q;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sel[i] = (chan_q == CHAN_BITS'(i));
    end
  end

  assign rx_bit    = |(mdio_rx_data & sel);
  assign tx_en_cur = !(read_q && (bits_q <= TA_BITS));

  always_comb begin
    mdc          = '0;
    mdio_tx_data = '0;
    mdio_tx_en   = '0;
    chan_busy    = '0;
    if (state_q == SHIFT) begin
      mdc          = high_q ? sel : '0;
      mdio_tx_en   = tx_en_cur ? sel : '0;
      mdio_tx_data = (tx_en_cur && frame_q[63]) ? sel : '0;
    end
    if ((state_q == SHIFT) || (state_q == DONE)) begin
      chan_busy = sel;
    end
  end

  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    div_d       = div_q;
    high_d      = high_q;
    bits_d      = bits_q;
    frame_d     = frame_q;
    rd_d        = rd_q;
    read_d      = read_q;
    chan_d      = chan_q;
    chan_ok_d   = chan_ok_q;
    rsp_valid_d = 1'b0;
    rsp_chan_d  = rsp_chan_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      GATED: begin
        gate_d = gate_q + 1'b1;
        if (gate_q == GATE_LAST) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          chan_d    = bus.cmd_chan;
          chan_ok_d = (32'(bus.cmd_chan) < NUM_CHANNELS);
          read_d    = is_read(bus.cmd_c45, bus.cmd_op);
          frame_d   = build_frame(bus.cmd_c45, bus.cmd_op, bus.cmd_phy_addr,
                                  bus.cmd_reg_addr, bus.cmd_data);
          bits_d    = BITS_INIT;
          div_d     = '0;
          high_d    = 1'b0;
          // a channel that does not exist completes immediately with the bus-float value
          state_d   = (32'(bus.cmd_chan) < NUM_CHANNELS) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          high_d = ~high_q;
          if (!high_q) begin
            rd_d = {rd_q[14:0], rx_bit};
          end else begin
            frame_d = {frame_q[62:0], 1'b0};
            bits_d  = bits_q - 1'b1;
            if (bits_q == BITS_ONE) state_d = DONE;
          end
        end
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_chan_d  = chan_q;
        rsp_data_d  = !chan_ok_q ? 16'hFFFF : (read_q ? rd_q : 16'h0000);
        state_d     = IDLE;
      end
      default: state_d = GATED;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= GATED;
      gate_q      <= '0;
      div_q       <= '0;
      high_q      <= 1'b0;
      bits_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_chan_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      div_q       <= div_d;
      high_q      <= high_d;
      bits_q      <= bits_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_chan_q  <= rsp_chan_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // frame contents only matter while the control state says they are live
  always_ff @(posedge sys_clk) begin
    frame_q   <= frame_d;
    rd_q      <= rd_d;
    read_q    <= read_d;
    chan_q    <= chan_d;
    chan_ok_q <= chan_ok_d;
  end
endmodule

// File: tb/tb_mdio_bank_controller.sv
// Directed bench: one instance with preamble and one without, a PHY model answering reads,
// and a scoreboard of expected completions popped when rsp_valid arrives.
module tb_mdio_bank_controller;
  localparam int NCH  = 3;
  localparam int CB   = 2;
  localparam int DIV  = 2;
  localparam int GATE = 16;

  typedef struct {
    logic [CB-1:0] ch;
    logic [15:0]   data;
    int            lat;
    int            nb;
    logic [63:0]   frame;
    logic [63:0]   en;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdio_bank_controller_if #(.CHAN_BITS(CB)) if_a ();
  mdio_bank_controller_if #(.CHAN_BITS(CB)) if_n ();

  logic [NCH-1:0] busy_a, mdc_a, txd_a, txe_a;
  logic [NCH-1:0] busy_n, mdc_n, txd_n, txe_n;
  logic [NCH-1:0] rx = '1;

  mdio_bank_controller #(.NUM_CHANNELS(NCH), .CHAN_BITS(CB), .CLK_DIV(DIV),
                         .PREAMBLE_EN(1), .GATE_CYCLES(GATE)) dut (
    .sys_clk(clk), .rst(rst), .bus(if_a), .chan_busy(busy_a), .mdc(mdc_a),
    .mdio_tx_data(txd_a), .mdio_tx_en(txe_a), .mdio_rx_data(rx));

  mdio_bank_controller #(.NUM_CHANNELS(NCH), .CHAN_BITS(CB), .CLK_DIV(DIV),
                         .PREAMBLE_EN(0), .GATE_CYCLES(GATE)) dut_np (
    .sys_clk(clk), .rst(rst), .bus(if_n), .chan_busy(busy_n), .mdc(mdc_n),
    .mdio_tx_data(txd_n), .mdio_tx_en(txe_n), .mdio_rx_data(rx));

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  logic        sel_np = 1'b0;
  int          mon_ch = 0;
  int          nbits = 64;
  logic [15:0] phy_word = 16'hFFFF;
  int          cap_base = 0;
  int          n_rsp_a = 0;

  // written only by the monitor
  logic [63:0]    cap_d = '0;
  logic [63:0]    cap_e = '0;
  int             cap_n = 0;
  int             act_any_n = 0;
  int             act_oth_n = 0;
  int             rsp_pulses = 0;
  logic [NCH-1:0] mdc_prev = '0;

  function automatic logic f_rdy();
    return sel_np ? if_n.cmd_ready : if_a.cmd_ready;
  endfunction
  function automatic logic f_rspv();
    return sel_np ? if_n.rsp_valid : if_a.rsp_valid;
  endfunction
  function automatic logic [CB-1:0] f_rspc();
    return sel_np ? if_n.rsp_chan : if_a.rsp_chan;
  endfunction
  function automatic logic [15:0] f_rspd();
    return sel_np ? if_n.rsp_data : if_a.rsp_data;
  endfunction
  function automatic logic [NCH-1:0] f_busy();
    return sel_np ? busy_n : busy_a;
  endfunction
  function automatic logic [NCH-1:0] f_mdc();
    return sel_np ? mdc_n : mdc_a;
  endfunction
  function automatic logic [NCH-1:0] f_txd();
    return sel_np ? txd_n : txd_a;
  endfunction
  function automatic logic [NCH-1:0] f_txe();
    return sel_np ? txe_n : txe_a;
  endfunction

  // Pin monitor and PHY model: capture bits on MDC rise, drive the next read bit after MDC fall
  always @(negedge clk) begin
    logic [NCH-1:0] m, d, e;
    int idx;
    m = f_mdc();
    d = f_txd();
    e = f_txe();
    if (if_a.rsp_valid) rsp_pulses++;
    for (int i = 0; i < NCH; i++) begin
      if (m[i] | d[i] | e[i]) begin
        act_any_n++;
        if (i != mon_ch) act_oth_n++;
      end
    end
    if (m[mon_ch] && !mdc_prev[mon_ch]) begin
      cap_d = {cap_d[62:0], d[mon_ch]};
      cap_e = {cap_e[62:0], e[mon_ch]};
      cap_n++;
    end
    if (!m[mon_ch] && mdc_prev[mon_ch]) begin
      idx = cap_n - cap_base;
      rx[mon_ch] = (idx >= nbits - 16 && idx < nbits) ? phy_word[nbits - 1 - idx] : 1'b1;
    end
    mdc_prev = m;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic np, input int ch, input logic c45, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] data,
                       input logic [15:0] rdval, output int waited);
    exp_t e;
    logic rd;
    logic [31:0] f32;
    int act_base;
    logic [63:0] en_mask;
    sel_np   = np;
    mon_ch   = (ch < NCH) ? ch : 0;
    nbits    = np ? 32 : 64;
    rd       = c45 ? op[1] : (op == 2'b10);
    phy_word = rd ? rdval : 16'hFFFF;
    cap_base = cap_n;
    act_base = act_any_n;
    if_a.cmd_chan = CB'(ch);      if_n.cmd_chan = CB'(ch);
    if_a.cmd_c45 = c45;           if_n.cmd_c45 = c45;
    if_a.cmd_op = op;             if_n.cmd_op = op;
    if_a.cmd_phy_addr = phy;      if_n.cmd_phy_addr = phy;
    if_a.cmd_reg_addr = ra;       if_n.cmd_reg_addr = ra;
    if_a.cmd_data = data;         if_n.cmd_data = data;
    if (np) if_n.cmd_valid = 1'b1;
    else    if_a.cmd_valid = 1'b1;
    waited = 0;
    while (!f_rdy() && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_seen", f_rdy(), 1);
    chk("pins_quiet_before_accept", act_any_n - act_base, 0);
    f32      = {1'b0, ~c45, op, phy, ra, 2'b10, data};
    en_mask  = np ? 64'h0000_0000_FFFF_FFFF : '1;
    e.ch     = CB'(ch);
    e.nb     = (ch < NCH) ? nbits : 0;
    e.data   = (ch >= NCH) ? 16'hFFFF : (rd ? rdval : 16'h0000);
    e.lat    = (ch >= NCH) ? 2 : nbits * 2 * DIV + 2;
    e.frame  = np ? {32'h0, f32} : {32'hFFFF_FFFF, f32};
    e.en     = rd ? (en_mask & ~64'h3FFFF) : en_mask;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    if_a.cmd_valid = 1'b0;
    if_n.cmd_valid = 1'b0;
    chk("ready_falls_after_accept", f_rdy(), 0);
    chk("chan_busy_onehot", f_busy(), (ch < NCH) ? (64'd1 << ch) : 64'd0);
  endtask

  task automatic collect();
    exp_t e;
    int lat;
    int oth_base;
    oth_base = act_oth_n - 0;
    lat = 1;
    while (!f_rspv() && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_seen", f_rspv(), 1);
    chk("scoreboard_entry", sb.size(), 1);
    e = '{default: '0};
    if (sb.size() > 0) e = sb.pop_front();
    if (!sel_np) n_rsp_a++;
    chk("rsp_latency", lat, e.lat);
    chk("rsp_chan", f_rspc(), e.ch);
    chk("rsp_data", f_rspd(), e.data);
    chk("busy_clear_at_rsp", f_busy(), 0);
    chk("ready_low_at_rsp", f_rdy(), 0);
    chk("mdc_rise_count", cap_n - cap_base, e.nb);
    if (e.nb != 0) begin
      chk("frame_bits", cap_d & e.en, e.frame & e.en);
      chk("frame_tx_en", cap_e & (e.nb == 64 ? '1 : 64'hFFFF_FFFF), e.en);
    end
    @(negedge clk);
    chk("rsp_one_cycle", f_rspv(), 0);
    chk("ready_back", f_rdy(), 1);
  endtask

  initial begin
    int w, g, base, oth0, any0;
    if_a.cmd_valid = 1'b0; if_n.cmd_valid = 1'b0;
    if_a.cmd_chan = '0;    if_n.cmd_chan = '0;
    if_a.cmd_c45 = 1'b0;   if_n.cmd_c45 = 1'b0;
    if_a.cmd_op = '0;      if_n.cmd_op = '0;
    if_a.cmd_phy_addr = '0; if_n.cmd_phy_addr = '0;
    if_a.cmd_reg_addr = '0; if_n.cmd_reg_addr = '0;
    if_a.cmd_data = '0;    if_n.cmd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {if_a.cmd_ready, if_a.rsp_valid, if_a.rsp_chan, if_a.rsp_data,
                          busy_a, mdc_a, txd_a, txe_a}, 0);
    chk("reset_outputs_np", {if_n.cmd_ready, if_n.rsp_valid, busy_n, mdc_n, txe_n}, 0);

    // gating with cmd_valid held, then Clause 22 write on chan 1
    rst = 1'b0;
    oth0 = act_oth_n;
    issue(0, 1, 0, 2'b01, 5'h01, 5'h00, 16'h1140, 16'h0000, w);
    chk("gate_wait_cycles", w, GATE);
    collect();
    chk("c22_wr_other_chans_quiet", act_oth_n - oth0, 0);

    // Clause 22 read on chan 0
    oth0 = act_oth_n;
    issue(0, 0, 0, 2'b10, 5'h03, 5'h02, 16'h0000, 16'h7949, w);
    collect();
    chk("c22_rd_other_chans_quiet", act_oth_n - oth0, 0);

    // Clause 45 address frame then read on chan 2
    issue(0, 2, 1, 2'b00, 5'h01, 5'h01, 16'h0002, 16'h0000, w);
    collect();
    issue(0, 2, 1, 2'b11, 5'h01, 5'h01, 16'h0000, 16'hBEEF, w);
    collect();

    // no preamble: 32-bit frames
    issue(1, 2, 0, 2'b01, 5'h1F, 5'h11, 16'hA5A5, 16'h0000, w);
    collect();
    issue(1, 1, 0, 2'b10, 5'h04, 5'h1E, 16'h0000, 16'h1234, w);
    collect();

    // nonexistent channel
    any0 = act_any_n;
    issue(0, 3, 0, 2'b10, 5'h01, 5'h01, 16'h0000, 16'h0000, w);
    collect();
    chk("bad_chan_no_pin_activity", act_any_n - any0, 0);

    // reset in the middle of a frame
    base = rsp_pulses;
    issue(0, 2, 0, 2'b01, 5'h07, 5'h09, 16'hC3C3, 16'h0000, w);
    g = 0;
    while ((cap_n - cap_base) < 40 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("abort_reached_bit40", (cap_n - cap_base) >= 40, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pins_cleared", {mdc_a, txe_a, txd_a, busy_a}, 0);
    chk("abort_ctrl_cleared", {if_a.cmd_ready, if_a.rsp_valid}, 0);
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    issue(0, 0, 0, 2'b01, 5'h02, 5'h03, 16'h0F0F, 16'h0000, w);
    chk("regate_wait_cycles", w, GATE);
    collect();
    chk("abort_no_rsp", rsp_pulses - base, 1);
    chk("rsp_pulse_total", rsp_pulses, n_rsp_a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
